// File: rtl/pdm_cic_decimator.sv
// PDM microphone front end: generates the PDM clock, samples the 1-bit stream and
// decimates it through an ORDER-stage CIC filter into saturated signed 16-bit PCM.
module pdm_cic_decimator #(
  parameter int DECIMATION = 64,
  parameter int ORDER      = 4,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 enable_i,
  input  logic [DIV_WIDTH-1:0] clock_divisor_i,
  input  logic                 pdm_data_i,
  output logic                 pdm_clk_o,
  output logic                 pdm_lrsel_o,
  output logic [15:0]          pcm_sample_o,
  output logic                 pcm_valid_o,
  input  logic                 pcm_ready_i,
  output logic                 overrun_o
);

  localparam int LOG2D = $clog2(DECIMATION);
  localparam int W     = ORDER * LOG2D + 2;
  localparam int SH    = ORDER * LOG2D - 15;
  localparam int SHR   = (SH > 0) ? SH : 0;
  localparam int SHL   = (SH < 0) ? -SH : 0;
  localparam int EW    = W + 16;
  localparam int SUW   = $clog2(ORDER + 1);
  localparam logic [SUW-1:0]   SU_DONE   = SUW'(ORDER);
  localparam logic [LOG2D-1:0] DCNT_LAST = LOG2D'(DECIMATION - 1);

  function automatic logic [15:0] sat16(input logic [EW-1:0] v);
    logic [15:0] r;
    if ((v[EW-1:15] == {(EW-15){1'b0}}) || (v[EW-1:15] == {(EW-15){1'b1}})) begin
      r = v[15:0];
    end else if (v[EW-1]) begin
      r = 16'h8000;
    end else begin
      r = 16'h7fff;
    end
    return r;
  endfunction

  logic [DIV_WIDTH-1:0]    div_q, div_d;
  logic                    pclk_q, pclk_d;
  logic [LOG2D-1:0]        dcnt_q, dcnt_d;
  logic                    wrap_q, wrap_d;
  logic [ORDER-1:0][W-1:0] integ_q, integ_d;
  logic [W-1:0]            dec_q, dec_d;
  logic                    dec_vld_q, dec_vld_d;
  logic [ORDER-1:0][W-1:0] dly_q, dly_d;
  logic [SUW-1:0]          su_q, su_d;
  logic [15:0]             sample_q, sample_d;
  logic                    valid_q, valid_d;
  logic                    ovr_q, ovr_d;

  logic                    samp_edge_s;
  logic                    load_s;
  logic [W-1:0]            x_s;
  logic [W-1:0]            acc_s;
  logic [W-1:0]            stage_s;
  logic [ORDER-1:0][W-1:0] cin_s;
  logic signed [EW-1:0]    ext_s;
  logic signed [EW-1:0]    shifted_s;

  // Next-state logic: divider, integrators, decimation latch, comb cascade and handshake.
  always_comb begin
    div_d       = div_q;
    pclk_d      = pclk_q;
    dcnt_d      = dcnt_q;
    wrap_d      = 1'b0;
    integ_d     = integ_q;
    dec_d       = dec_q;
    dec_vld_d   = 1'b0;
    dly_d       = dly_q;
    su_d        = su_q;
    sample_d    = sample_q;
    valid_d     = valid_q;
    ovr_d       = 1'b0;
    samp_edge_s = 1'b0;
    load_s      = 1'b0;
    x_s         = pdm_data_i ? W'(1) : {W{1'b1}};
    acc_s       = x_s;
    stage_s     = dec_q;
    cin_s       = dly_q;
    for (int k = 0; k < ORDER; k++) begin
      cin_s[k] = stage_s;
      stage_s  = stage_s - dly_q[k];
    end
    ext_s     = {{16{stage_s[W-1]}}, stage_s};
    shifted_s = (ext_s >>> SHR) <<< SHL;

    if (!enable_i) begin
      div_d     = {DIV_WIDTH{1'b0}};
      pclk_d    = 1'b0;
      dcnt_d    = {LOG2D{1'b0}};
      integ_d   = {(ORDER*W){1'b0}};
      dec_d     = {W{1'b0}};
      dly_d     = {(ORDER*W){1'b0}};
      su_d      = {SUW{1'b0}};
      sample_d  = 16'h0000;
      valid_d   = 1'b0;
    end else begin
      // The divisor is only sampled at a reload, so a change never shortens a half-period.
      if (div_q == {DIV_WIDTH{1'b0}}) begin
        pclk_d      = ~pclk_q;
        div_d       = clock_divisor_i;
        samp_edge_s = ~pclk_q;
      end else begin
        div_d = div_q - DIV_WIDTH'(1);
      end

      // Integrators wrap modulo 2^W by design; the comb differences undo the wrap.
      if (samp_edge_s) begin
        for (int k = 0; k < ORDER; k++) begin
          integ_d[k] = integ_q[k] + acc_s;
          acc_s      = integ_d[k];
        end
        dcnt_d = dcnt_q + LOG2D'(1);
        wrap_d = (dcnt_q == DCNT_LAST);
      end else begin
        wrap_d = 1'b0;
      end

      if (wrap_q) begin
        dec_d     = integ_q[ORDER-1];
        dec_vld_d = 1'b1;
      end else begin
        dec_vld_d = 1'b0;
      end

      if (dec_vld_q) begin
        dly_d = cin_s;
        if (su_q == SU_DONE) begin
          load_s = 1'b1;
        end else begin
          su_d = su_q + SUW'(1);
        end
      end else begin
        load_s = 1'b0;
      end

      if (load_s) begin
        sample_d = sat16(shifted_s);
        valid_d  = 1'b1;
        ovr_d    = valid_q & ~pcm_ready_i;
      end else if (valid_q && pcm_ready_i) begin
        valid_d = 1'b0;
      end else begin
        valid_d = valid_q;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div_q     <= {DIV_WIDTH{1'b0}};
      pclk_q    <= 1'b0;
      dcnt_q    <= {LOG2D{1'b0}};
      wrap_q    <= 1'b0;
      integ_q   <= {(ORDER*W){1'b0}};
      dec_q     <= {W{1'b0}};
      dec_vld_q <= 1'b0;
      dly_q     <= {(ORDER*W){1'b0}};
      su_q      <= {SUW{1'b0}};
      sample_q  <= 16'h0000;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      div_q     <= div_d;
      pclk_q    <= pclk_d;
      dcnt_q    <= dcnt_d;
      wrap_q    <= wrap_d;
      integ_q   <= integ_d;
      dec_q     <= dec_d;
      dec_vld_q <= dec_vld_d;
      dly_q     <= dly_d;
      su_q      <= su_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

  assign pdm_clk_o    = pclk_q;
  assign pdm_lrsel_o  = 1'b0;
  assign pcm_sample_o = sample_q;
  assign pcm_valid_o  = valid_q;
  assign overrun_o    = ovr_q;

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Scoreboard bench: a microphone model records every sampled bit, an FIR-equivalent
// CIC model predicts each PCM sample, and a monitor compares outputs cycle by cycle.
module tb_pdm_cic_decimator;

  localparam int D   = 64;
  localparam int ORD = 4;
  localparam int DW  = 8;
  localparam int SH  = ORD * 6 - 15;
  localparam int L   = ORD * (D - 1) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [DW-1:0] div = 8'd0;
  logic          pdm_data = 1'b0;
  logic          ready = 1'b1;
  logic          pdm_clk;
  logic          pdm_lrsel;
  logic [15:0]   pcm_sample;
  logic          pcm_valid;
  logic          overrun;

  pdm_cic_decimator #(.DECIMATION(D), .ORDER(ORD), .DIV_WIDTH(DW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .clock_divisor_i(div),
    .pdm_data_i(pdm_data), .pdm_clk_o(pdm_clk), .pdm_lrsel_o(pdm_lrsel),
    .pcm_sample_o(pcm_sample), .pcm_valid_o(pcm_valid), .pcm_ready_i(ready),
    .overrun_o(overrun)
  );

  always #5 clk = ~clk;

  typedef struct { int val; int cyc; } exp_t;
  exp_t    exp_q[$];
  int      hist[$];
  longint  h[];
  int      total = 0;
  int      bad = 0;
  int      cyc = 0;
  int      mode = 0;
  int      settle = 0;
  int      last_rise = 0;
  int      presented = 0;
  bit      have_last = 1'b0;
  logic    m_valid = 1'b0;
  int      m_val = 0;
  logic    prev_ready = 1'b1;
  logic    prev_en = 1'b0;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic next_bit(input int idx);
    logic b;
    case (mode)
      0:       b = ($urandom_range(0, 1) == 1);
      1:       b = 1'b1;
      2:       b = 1'b0;
      3:       b = idx[0];
      default: b = ($urandom_range(0, 99) < 75);
    endcase
    return b;
  endfunction

  // CIC equals an FIR with a boxcar(D) convolved ORDER times, starting from zero history.
  function automatic int model_out();
    longint y = 0;
    int n = hist.size();
    for (int k = 0; k < L; k++) begin
      if (n - 1 - k >= 0) y += h[k] * longint'(hist[n-1-k]);
    end
    y = y >>> SH;
    if (y > 32767) y = 32767;
    if (y < -32768) y = -32768;
    return int'(y);
  endfunction

  task automatic clear_model();
    exp_q.delete();
    hist.delete();
    have_last = 1'b0;
    m_valid = 1'b0;
    pdm_data = next_bit(0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pdm_clk"}, pdm_clk, 0);
    check({tag, "_lrsel"}, pdm_lrsel, 0);
    check({tag, "_sample"}, pcm_sample, 0);
    check({tag, "_valid"}, pcm_valid, 0);
    check({tag, "_overrun"}, overrun, 0);
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Microphone model: record the bit sampled at each PDM rising edge, then present the next.
  initial begin
    forever begin
      @(posedge pdm_clk);
      if (rst_n) begin
        hist.push_back(pdm_data ? 1 : -1);
        if (settle > 0) settle--;
        else if (have_last) check("pdm_period", cyc - last_rise, 2 * (int'(div) + 1));
        have_last = 1'b1;
        last_rise = cyc;
        if ((hist.size() % D == 0) && (hist.size() / D > ORD))
          exp_q.push_back('{model_out(), cyc + 3});
        pdm_data = next_bit(hist.size());
      end
    end
  end

  // Output monitor: expected valid/overrun/sample derived from the scoreboard queue.
  initial begin
    logic exp_ovr;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (!prev_en) begin
          clear_model();
          check("dis_valid", pcm_valid, 0);
          check("dis_overrun", overrun, 0);
          check("dis_pdm_clk", pdm_clk, 0);
        end else begin
          exp_ovr = 1'b0;
          if ((exp_q.size() > 0) && (exp_q[0].cyc == cyc)) begin
            exp_ovr = m_valid && !prev_ready;
            m_valid = 1'b1;
            m_val = exp_q[0].val;
            void'(exp_q.pop_front());
            presented++;
          end else if (m_valid && prev_ready) begin
            m_valid = 1'b0;
          end
          check("valid", pcm_valid, m_valid);
          check("overrun", overrun, exp_ovr);
          if (m_valid) check("sample", $signed(pcm_sample), m_val);
        end
      end
      prev_ready = ready;
      prev_en = enable;
    end
  end

  initial begin
    longint tmp[];
    bit got;
    h = new[1];
    h[0] = 1;
    repeat (ORD) begin
      tmp = new[h.size() + D - 1];
      foreach (tmp[i]) tmp[i] = 0;
      foreach (h[i]) for (int j = 0; j < D; j++) tmp[i+j] += h[i];
      h = tmp;
    end

    enable = 1'b1;
    div = 8'd0;
    ready = 1'b1;
    mode = 0;
    pdm_data = next_bit(0);
    #1;
    check_all_zero("reset");
    run(3);
    rst_n = 1'b1;

    run(12 * 128);
    mode = 1; run(8 * 128);
    mode = 2; run(8 * 128);
    mode = 3; run(8 * 128);
    mode = 4; run(6 * 128);

    mode = 0;
    ready = 1'b0; run(3 * 128 + 50);
    ready = 1'b1; run(2 * 128);

    for (int i = 0; i < 10 * 128; i++) begin
      @(posedge clk); #2;
      ready = ($urandom_range(0, 7) == 0);
    end
    ready = 1'b1;

    run(37);
    div = 8'd3; settle = 2;
    run(6 * 512);
    div = 8'd0; settle = 2;
    run(2 * 128);

    ready = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (pcm_valid) begin
        got = 1'b1;
        break;
      end
    end
    check("pending_found", got, 1);
    run(1);
    enable = 1'b0;
    run(10);
    enable = 1'b1;
    ready = 1'b1;
    mode = 4;
    run(7 * 128);

    run(301);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    clear_model();
    run(3);
    rst_n = 1'b1;
    mode = 0;
    run(7 * 128);

    check("presented_enough", (presented >= 40) ? 1 : 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pdm_cic_decimator.md
Name: pdm_cic_decimator

Overview:
- Front-end stage of the audio capture path: drives the PDM microphone clock, samples the 1-bit PDM stream and converts it to signed 16-bit PCM.
- Conversion uses an ORDER-stage CIC decimation filter.
- PCM samples go over a valid/ready handshake to the audio capture unit's sample buffer.
- Runtime control (enable, clock divisor) comes from the capture unit's control register.

Parameters:
- DECIMATION, 64, PDM bits per PCM sample; power of two, 8..256.
- ORDER, 4, number of CIC integrator and comb stages; 1..5.
- DIV_WIDTH, 8, width of the PDM clock half-period divisor.

Ports:
- clk_i  in  1  system clock; the only clock of the block.
- rst_n_i  in  1  asynchronous active-low reset.
- enable_i  in  1  conversion enable, level-sensitive.
- clock_divisor_i  in  DIV_WIDTH  PDM clock half-period minus one, in clk_i cycles.
- pdm_data_i  in  1  microphone data.
- pdm_clk_o  out  1  microphone clock.
- pdm_lrsel_o  out  1  channel select; constant 0 (left channel, data valid at rising edge).
- pcm_sample_o  out  16  signed PCM sample.
- pcm_valid_o  out  1  pcm_sample_o holds an unconsumed sample.
- pcm_ready_i  in  1  consumer accepts the sample.
- overrun_o  out  1  one-cycle pulse: an unconsumed sample was overwritten.

Behaviour:
- Interface: one clock, clk_i. Reset rst_n_i is asynchronous, active-low. Asserting it clears, independent of clk_i:
  - all outputs to 0 (pdm_lrsel_o is constant 0);
  - the divider, decimation counter, startup counter, integrators and comb delay lines.
- Clock divider:
  - While enable_i=1, pdm_clk_o toggles every clock_divisor_i+1 clk_i cycles.
  - Divisor 0 gives clk_i/2.
  - A divisor change takes effect at the next half-period reload and never truncates the current half-period.
  - While enable_i=0, pdm_clk_o is held 0.
- Sampling: pdm_data_i is registered on the clk_i edge at which pdm_clk_o goes 0->1. Mapping: 1 -> +1, 0 -> -1.
- Arithmetic:
  - Internal width W = ORDER*log2(DECIMATION)+2, signed two's complement.
  - Integrators wrap modulo 2^W. This is intentional and required for CIC correctness; no saturation.
- Cycle S (sampling edge): all ORDER integrators update, cascaded (each adds the previous stage's new value). The decimation counter increments modulo DECIMATION.
- Cycle S+1: if the counter wrapped at S, the last integrator output is latched as the decimated value.
- Cycle S+2: the comb cascade result (y = x - x delayed by one decimated sample, per stage) is registered. The output is formed and pcm_valid_o asserts.
  - Latency from the sampling edge of the DECIMATION-th bit to pcm_valid_o is 2 clk_i cycles.
- Output scaling: pcm_sample_o = saturate16(comb >>> (ORDER*log2(DECIMATION)-15)). Full scale is +32767 / -32768.
- Startup: after enable rises (or after reset), the first ORDER decimated results are computed but not presented. The startup counter suppresses them while the comb delay lines fill.
- Handshake:
  - A sample transfers on a cycle with pcm_valid_o=1 and pcm_ready_i=1.
  - pcm_sample_o is stable while valid and not ready.
  - pcm_valid_o falls on the cycle after transfer unless a new sample is loaded in that same cycle.
- Simultaneous events:
  - New sample with valid=1 and ready=1: the old sample transfers, the new one loads, valid stays 1, no overrun.
  - New sample with valid=1 and ready=0: the new sample overwrites the old one and overrun_o pulses for 1 cycle.
- Disable mid-operation (enable_i 1->0): on the next clk_i edge, pdm_clk_o goes 0 and pcm_valid_o goes 0. A pending sample is dropped without an overrun pulse. All filter state clears.
- Re-enable: restarts from the cleared state, including the startup suppression.

Test Plan:
- Reset, enable=1, divisor=0, pcm_ready_i=1 -> pdm_clk_o period 2 clk_i cycles; first pcm_valid_o appears after (ORDER+1)*DECIMATION PDM bits = 320.
- pdm_data_i constant 1, DECIMATION=64, ORDER=4 -> after startup every sample is +32767; constant 0 -> -32768; each valid exactly 2 cycles after the 64th sampling edge.
- Alternating 1/0 PDM stream -> steady-state samples equal 0 ±1; integrator wrap never corrupts the output.
- pcm_ready_i held 0 across two decimation periods -> sample 1 held stable, then replaced by sample 2, overrun_o high for exactly 1 cycle; ready and new sample in the same cycle -> no overrun.
- Divisor changed 0->3 mid half-period -> the current half-period completes, then pdm_clk_o period becomes 8 cycles.
- enable_i dropped with valid pending, then raised -> valid clears next cycle, pdm_clk_o low, no overrun; startup suppression repeats. Async reset mid-sample -> all outputs 0 immediately.
